// File: rtl/vmem_pkg.sv
// Shared op-field layout, access patterns and sequencer state for the vector memory subvector path.
// Pure definitions: no latency, no backpressure.
package vmem_pkg;

    localparam int NUMLANES_DEF = 8;

    localparam int OP_W       = 7;
    localparam int OP_MEMOP   = 6;
    localparam int OP_PAT_HI  = 5;
    localparam int OP_PAT_LO  = 4;
    localparam int OP_SIZE_HI = 3;
    localparam int OP_SIZE_LO = 2;
    localparam int OP_SIGNED  = 1;
    localparam int OP_WE      = 0;

    typedef enum logic [1:0] {
        PAT_UNIT    = 2'd0,
        PAT_STRIDED = 2'd1,
        PAT_INDEXED = 2'd2
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/vmem_lane_mask_gen.sv
// Remaining-element count to active-lane mask plus final-subvector flag.
// Purely combinational; no backpressure.
module vmem_lane_mask_gen #(
    parameter int NUMLANES = 8,
    parameter int VLWIDTH  = 8
) (
    input  logic [VLWIDTH-1:0]  rem_i,
    output logic [NUMLANES-1:0] mask_o,
    output logic                last_o
);

    always_comb begin
        mask_o = '0;
        for (int i = 0; i < NUMLANES; i++) begin
            mask_o[i] = (rem_i > VLWIDTH'(i));
        end
    end

    assign last_o = (rem_i <= VLWIDTH'(NUMLANES));

endmodule

// File: rtl/vmem_subvec_seq.sv
// Splits one vector memory instruction into NUMLANES-wide subvector issues; issue is same-cycle, writeback 1 cycle later.
// stall holds all state and suppresses en; in_ready only while idle.
module vmem_subvec_seq
    import vmem_pkg::*;
#(
    parameter int NUMLANES    = NUMLANES_DEF,
    parameter int LOGMEMDEPTH = 11,
    parameter int VCWIDTH     = 32,
    parameter int VLWIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [LOGMEMDEPTH-1:0] in_base,
    input  logic [VCWIDTH-1:0]     in_stride,
    input  logic [VLWIDTH-1:0]     in_vl,
    input  logic                   stall,
    output logic                   en,
    output logic [OP_W-1:0]        op,
    output logic [LOGMEMDEPTH-1:0] address_a,
    output logic [VCWIDTH-1:0]     stride_val_a,
    output logic                   last_subvector,
    output logic [NUMLANES-1:0]    lane_mask,
    output logic                   wb_valid,
    output logic                   wb_last,
    output logic [NUMLANES-1:0]    wb_mask,
    output logic                   done
);

    localparam logic [VLWIDTH-1:0] NL_V = VLWIDTH'(NUMLANES);

    state_e                 state_q;
    logic [OP_W-1:0]        op_q;
    logic [LOGMEMDEPTH-1:0] base_q;
    logic [LOGMEMDEPTH-1:0] step_q;
    logic [LOGMEMDEPTH-1:0] step_d;
    logic [VCWIDTH-1:0]     stride_q;
    logic [VLWIDTH-1:0]     rem_q;
    logic [VLWIDTH-1:0]     k_q;
    logic                   done_q;
    logic                   wb_valid_q;
    logic                   wb_last_q;
    logic [NUMLANES-1:0]    wb_mask_q;

    logic                   busy;
    logic                   accept;
    logic                   no_work;
    logic [NUMLANES-1:0]    gen_mask;
    logic                   gen_last;

    vmem_lane_mask_gen #(
        .NUMLANES (NUMLANES),
        .VLWIDTH  (VLWIDTH)
    ) u_mask_gen (
        .rem_i  (rem_q),
        .mask_o (gen_mask),
        .last_o (gen_last)
    );

    assign busy    = (state_q == ST_BUSY);
    assign accept  = in_valid & ~busy;
    assign no_work = (in_vl == '0) | ~in_op[OP_MEMOP];

    // Per-subvector address step, truncated to the memory depth so addresses wrap.
    always_comb begin
        step_d = '0;
        case (in_op[OP_PAT_HI:OP_PAT_LO])
            PAT_UNIT:    step_d = LOGMEMDEPTH'(NUMLANES);
            PAT_STRIDED: step_d = LOGMEMDEPTH'(in_stride * VCWIDTH'(NUMLANES));
            default:     step_d = '0;
        endcase
    end

    assign in_ready       = ~busy;
    assign en             = busy & ~stall;
    assign last_subvector = en & gen_last;
    assign lane_mask      = busy ? gen_mask : '0;
    assign op             = busy ? op_q : '0;
    assign address_a      = base_q + LOGMEMDEPTH'(k_q) * step_q;
    assign stride_val_a   = stride_q;
    assign wb_valid       = wb_valid_q;
    assign wb_last        = wb_last_q;
    assign wb_mask        = wb_mask_q;
    assign done           = done_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            base_q     <= '0;
            step_q     <= '0;
            stride_q   <= '0;
            rem_q      <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_last_q  <= 1'b0;
            wb_mask_q  <= '0;
        end else begin
            done_q     <= (accept & no_work) | (en & gen_last);
            wb_valid_q <= en & op[OP_MEMOP] & ~op[OP_WE];
            wb_last_q  <= last_subvector;
            wb_mask_q  <= lane_mask;
            if (!busy) begin
                if (accept) begin
                    op_q     <= in_op;
                    base_q   <= in_base;
                    stride_q <= in_stride;
                    step_q   <= step_d;
                    rem_q    <= in_vl;
                    k_q      <= '0;
                    if (!no_work) begin
                        state_q <= ST_BUSY;
                    end
                end
            end else if (en) begin
                rem_q <= gen_last ? '0 : rem_q - NL_V;
                k_q   <= k_q + VLWIDTH'(1);
                if (gen_last) begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vmem_subvec_seq.sv
// Bench for vmem_subvec_seq: directed scenarios plus random instructions against a transaction-list model.
module tb_vmem_subvec_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_op;
    logic [10:0] in_base;
    logic [31:0] in_stride;
    logic [7:0]  in_vl;
    logic        stall;
    logic        en;
    logic [6:0]  op;
    logic [10:0] address_a;
    logic [31:0] stride_val_a;
    logic        last_subvector;
    logic [7:0]  lane_mask;
    logic        wb_valid;
    logic        wb_last;
    logic [7:0]  wb_mask;
    logic        done;

    vmem_subvec_seq #(
        .NUMLANES(8), .LOGMEMDEPTH(11), .VCWIDTH(32), .VLWIDTH(8)
    ) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_base(in_base), .in_stride(in_stride), .in_vl(in_vl),
        .stall(stall), .en(en), .op(op), .address_a(address_a),
        .stride_val_a(stride_val_a), .last_subvector(last_subvector),
        .lane_mask(lane_mask), .wb_valid(wb_valid), .wb_last(wb_last),
        .wb_mask(wb_mask), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  mask;
        logic        last;
    } subvec_t;

    // Expected subvector issues of the instruction in flight, oldest first.
    subvec_t     sq[$];
    logic [6:0]  m_op      = '0;
    logic [31:0] m_stride  = '0;
    logic        pv_wbv    = 1'b0;
    logic        pv_wbl    = 1'b0;
    logic [7:0]  pv_wbm    = '0;
    logic        pv_done   = 1'b0;
    logic        prev_last = 1'b0;
    logic        after_rst = 1'b0;
    logic [10:0] iss[$];

    task automatic build(input logic [6:0] o, input logic [10:0] b, input logic [31:0] s, input logic [7:0] l);
        longint step;
        int     n;
        int     r;
        subvec_t e;
        case (o[5:4])
            2'd0:    step = 8;
            2'd1:    step = 8 * longint'(s);
            default: step = 0;
        endcase
        n = (int'(l) + 7) / 8;
        for (int j = 0; j < n; j++) begin
            r      = int'(l) - 8 * j;
            e.addr = 11'((longint'(b) + longint'(j) * step) % 2048);
            e.mask = (r >= 8) ? 8'hFF : 8'((1 << r) - 1);
            e.last = (j == n - 1);
            sq.push_back(e);
        end
    endtask

    task automatic cyc(input logic rn, input logic v, input logic [6:0] o, input logic [10:0] b,
                       input logic [31:0] s, input logic [7:0] l, input logic st);
        logic    mb;
        logic    exp_en;
        subvec_t f;
        logic    n_wbv, n_wbl, n_done;
        logic [7:0] n_wbm;
        @(negedge clk);
        resetn = rn; in_valid = v; in_op = o; in_base = b; in_stride = s; in_vl = l; stall = st;
        #1;
        mb = (sq.size() != 0);
        f  = mb ? sq[0] : '{addr: '0, mask: '0, last: 1'b0};
        exp_en = mb && !st;
        chk("in_ready", in_ready, !mb);
        chk("en", en, exp_en);
        chk("last_subvector", last_subvector, exp_en && f.last);
        chk("lane_mask", lane_mask, f.mask);
        chk("op", op, mb ? m_op : 7'd0);
        if (mb) begin
            chk("address_a", address_a, f.addr);
            chk("stride_val_a", stride_val_a, m_stride);
        end
        chk("wb_valid", wb_valid, pv_wbv);
        chk("wb_last", wb_last, pv_wbl);
        chk("wb_mask", wb_mask, pv_wbm);
        chk("done", done, pv_done);
        chk("last_gap", last_subvector & prev_last, 1'b0);
        if (after_rst) begin
            chk("rst_address_a", address_a, 11'd0);
            chk("rst_stride_val_a", stride_val_a, 32'd0);
        end
        if (en) iss.push_back(address_a);
        prev_last = last_subvector;

        n_wbv  = exp_en && m_op[6] && !m_op[0];
        n_wbl  = exp_en && f.last;
        n_wbm  = f.mask;
        n_done = exp_en && f.last;
        if (exp_en) void'(sq.pop_front());
        if (!mb && v) begin
            m_op     = o;
            m_stride = s;
            if (l == 0 || !o[6]) n_done = 1'b1;
            else build(o, b, s, l);
        end
        if (!rn) begin
            sq.delete();
            n_wbv = 1'b0; n_wbl = 1'b0; n_wbm = '0; n_done = 1'b0;
            prev_last = 1'b0;
        end
        after_rst = !rn;
        pv_wbv = n_wbv; pv_wbl = n_wbl; pv_wbm = n_wbm; pv_done = n_done;
        @(posedge clk);
    endtask

    task automatic issue(input logic [6:0] o, input logic [10:0] b, input logic [31:0] s,
                         input logic [7:0] l, input int force_st, input int pct);
        iss.delete();
        cyc(1'b1, 1'b1, o, b, s, l, 1'b0);
        for (int t = 0; t < 400 && sq.size() != 0; t++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 7'($urandom), 11'($urandom), $urandom, 8'($urandom),
                (t < force_st) ? 1'b1 : ($urandom_range(0, 99) < pct));
        end
        chk("drain_timeout", sq.size(), 0);
        sq.delete();
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_base = '0;
        in_stride = '0; in_vl = '0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_en", en, 1'b0);
        chk("reset_op", op, 7'd0);
        chk("reset_address_a", address_a, 11'd0);
        chk("reset_stride_val_a", stride_val_a, 32'd0);
        chk("reset_last", last_subvector, 1'b0);
        chk("reset_lane_mask", lane_mask, 8'd0);
        chk("reset_wb_valid", wb_valid, 1'b0);
        chk("reset_wb_last", wb_last, 1'b0);
        chk("reset_wb_mask", wb_mask, 8'd0);
        chk("reset_done", done, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);

        // Unit-stride load, base 5, vl 20.
        issue(7'h48, 11'd5, 32'd0, 8'd20, 0, 0);
        chk("unit_count", iss.size(), 3);
        chk("unit_addr0", iss[0], 11'd5);
        chk("unit_addr1", iss[1], 11'd13);
        chk("unit_addr2", iss[2], 11'd21);

        // Strided store wrapping past the top of memory.
        issue(7'h59, 11'd2040, 32'd3, 8'd16, 0, 0);
        chk("stride_count", iss.size(), 2);
        chk("stride_addr0", iss[0], 11'd2040);
        chk("stride_addr1", iss[1], 11'd16);

        // Single-subvector store with a 3-cycle stall at the start.
        issue(7'h49, 11'd100, 32'd0, 8'd8, 3, 0);
        chk("stall_count", iss.size(), 1);

        // Back-to-back single-subvector stores.
        issue(7'h49, 11'd7, 32'd0, 8'd8, 0, 0);
        chk("b2b_first", iss.size(), 1);
        issue(7'h49, 11'd9, 32'd0, 8'd8, 0, 0);
        chk("b2b_second", iss.size(), 1);

        // Zero-length and non-memory ops.
        issue(7'h48, 11'd0, 32'd0, 8'd0, 0, 0);
        chk("vl0_count", iss.size(), 0);
        issue(7'h08, 11'd3, 32'd0, 8'd20, 0, 0);
        chk("nomem_count", iss.size(), 0);

        // Reset after the first of three subvectors.
        cyc(1'b1, 1'b1, 7'h48, 11'd5, 32'd0, 8'd20, 1'b0);
        cyc(1'b1, 1'b0, 7'h00, 11'd0, 32'd0, 8'd0, 1'b0);
        cyc(1'b0, 1'b0, 7'h00, 11'd0, 32'd0, 8'd0, 1'b1);
        issue(7'h4A, 11'd50, 32'd0, 8'd12, 0, 0);
        chk("post_rst_count", iss.size(), 2);

        for (int n = 0; n < 60; n++) begin
            logic [6:0]  o;
            logic [31:0] s;
            logic [7:0]  l;
            o = {1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 2'($urandom), 1'($urandom), 1'($urandom)};
            s = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 5);
            l = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
            issue(o, 11'($urandom), s, l, 0, $urandom_range(0, 60));
        end

        repeat (3) cyc(1'b1, 1'b0, 7'h00, 11'd0, 32'd0, 8'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
